frame_scanout_reader: RTL and testbench
=======================================

// Module: frame_scanout_reader
// PURPOSE
// - Read-side partner of the graphics frame writer. Generates VGA timing and fetches pixels from the front framebuffer.
// - Owns front/back selection of the two frame buffers (A/B). Swaps them only at vblank start, on request from the writer.
// - Sits between the framebuffer read ports and the VGA pins.
// PARAMETERS
// - H_VIS 640 visible pixels/line; H_FP 16, H_SYNC 96, H_BP 48 (H_TOT = 800)
// - V_VIS 480 visible lines; V_FP 10, V_SYNC 2, V_BP 33 (V_TOT = 525)
// - COLOR_W 4 bits per colour channel
// - ADDR_W 19 framebuffer address width; must be >= clog2(FB_W*FB_H)
// PORTS
// - clk        in  1         pixel clock
// - rst        in  1         async, active-high reset
// - swap_req   in  1         writer finished back buffer; level, held until swap_ack
// - swap_ack   out 1         1-cycle pulse: buffers swapped
// - rd_buf     out 1         front buffer select, 0 = A, 1 = B
// - rd_en      out 1         framebuffer read strobe
// - rd_addr    out ADDR_W    pixel address = y*FB_W + x
// - rd_data    in  3*COLOR_W {r,g,b}, valid 1 cycle after rd_en
// - frame_start out 1        1-cycle pulse when counters reach (h=0, v=0)
// - hsync, vsync out 1       active-low sync
// - de         out 1         visible-region flag, aligned with rgb
// - r, g, b    out COLOR_W   pixel colour
// BEHAVIOUR
// - Reset values: h_cnt = v_cnt = 0; hsync = vsync = 1; de = rd_en = swap_ack = frame_start = 0; rgb = 0; rd_buf = 0; rd_addr = 0.
// - Counter stage (S0):
//   - h_cnt counts 0..H_TOT-1, then wraps to 0 and increments v_cnt.
//   - v_cnt counts 0..V_TOT-1, then wraps to 0.
//   - vis = (h_cnt < H_VIS) && (v_cnt < V_VIS).
// - Sync windows:
//   - hsync active (0) for H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC.
//   - vsync uses the same rule on v_cnt.
// - Address generation:
//   - No multiplier. rd_addr is an incrementing pointer, advanced on every rd_en.
//   - Cleared at (0,0).
//   - Never exceeds FB_W*FB_H-1 and never wraps mid-frame.
// - rd_en = vis in S0.
// - Pipeline:
//   - S0 issues the address.
//   - S1 memory returns rd_data.
//   - S2 registers r/g/b, de, hsync and vsync.
//   - Latency is 2 cycles from counter to pins. Sync/de are delayed 2 cycles so all pins stay aligned.
// - Blanking: when de = 0, r/g/b = 0 regardless of rd_data.
// - Swap point: the S0 cycle where h_cnt = 0 and v_cnt = V_VIS (vblank start).
//   - If swap_req = 1 at that cycle (including a request first raised in that cycle): rd_buf toggles on the next edge and swap_ack pulses 1 cycle.
//   - Otherwise no change; the request waits for the next frame.
//   - swap_req falling before the swap point cancels the request.
//   - At most one swap per frame. swap_req still high after ack does not swap again until the next vblank.
//   - rd_buf never changes while any visible pixel of the current frame is in flight.
// - frame_start pulses in the S0 cycle at (0,0). Not delayed.
// - Async rst mid-frame: all state returns to reset values immediately and scan restarts at (0,0) with rd_buf = 0. A pending swap is dropped.
// CONFIGURATION
// - SCANOUT_PIXEL_DOUBLE_EN defined:
//   - FB_W = H_VIS/2, FB_H = V_VIS/2.
//   - Each stored pixel is shown 2x2: rd_addr advances every 2nd visible pixel.
//   - At the end of an even visible line, rd_addr rewinds to that line's start; at the end of an odd line it continues.
//   - rd_en pulses only when the address advances or rewinds; each fetched value is held for 2 cycles in S2.
// - Not defined: FB_W = H_VIS, FB_H = V_VIS, one fetch per visible pixel.
// TESTING
// - Reset, run 800*525 cycles:
//   - hsync low exactly 96 cycles per line, starting at h=656 (+2 cycles latency).
//   - vsync low lines 490-491.
//   - frame_start period is 420000 cycles.
// - Memory model returns rd_data = rd_addr[11:0]:
//   - Pixel (x=5, y=2) shows rgb = 1285 & 12'hFFF on the pins.
//   - de is high for exactly 640*480 cycles per frame.
//   - rgb = 0 whenever de = 0.
// - Swap handshake:
//   - swap_req raised at v=100: rd_buf toggles at (0,480), swap_ack pulses once; drop req and check no second ack.
//   - req raised exactly in the (0,480) cycle is honoured in that same frame.
// - Held/cancelled requests:
//   - swap_req held across 3 frames gives exactly 3 toggles, 1 per vblank.
//   - req pulsed only at v=200 gives no swap.
// - Async rst at (h=300, v=250) with rd_buf = 1:
//   - Outputs hit reset values without waiting for a clock edge.
//   - Next frame_start comes 420000 cycles after release.
// - SCANOUT_PIXEL_DOUBLE_EN build:
//   - Lines 0 and 1 show identical address sequences 0,0,1,1,...,319,319.
//   - Line 2 starts at 320.
//   - Last fetched address is 76799.

Source files
------------

// File: rtl/frame_scanout_reader.sv
// VGA timing generator and front-framebuffer pixel fetcher with A/B swap at vblank start.
// Optional 2x2 pixel doubling is enabled by defining SCANOUT_PIXEL_DOUBLE_EN.
module frame_scanout_reader #(
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int COLOR_W = 4,
  parameter int ADDR_W  = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 swap_req,
  output logic                 swap_ack,
  output logic                 rd_buf,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [3*COLOR_W-1:0] rd_data,
  output logic                 frame_start,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [COLOR_W-1:0]   r,
  output logic [COLOR_W-1:0]   g,
  output logic [COLOR_W-1:0]   b
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

`ifdef SCANOUT_PIXEL_DOUBLE_EN
  localparam int FB_W = H_VIS / 2;
  localparam int FB_H = V_VIS / 2;
`else
  localparam int FB_W = H_VIS;
  localparam int FB_H = V_VIS;
`endif

  localparam logic [HW-1:0]     H_LAST    = HW'(H_TOT - 1);
  localparam logic [HW-1:0]     H_VIS_C   = HW'(H_VIS);
  localparam logic [HW-1:0]     HS_BEG    = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0]     HS_END    = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0]     V_LAST    = VW'(V_TOT - 1);
  localparam logic [VW-1:0]     V_VIS_C   = VW'(V_VIS);
  localparam logic [VW-1:0]     VS_BEG    = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0]     VS_END    = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

  logic [HW-1:0]          h_cnt_r, h_nxt_s;
  logic [VW-1:0]          v_cnt_r, v_nxt_s;
  logic                   vis_r;
  logic                   vis_nxt_s, issue_nxt_s, origin_nxt_s;
  logic                   hs_act_s, vs_act_s, swap_pt_s;
  logic                   s1_de_r, s1_fetch_r, s1_hs_r, s1_vs_r;
  logic [3*COLOR_W-1:0]   pix_r;
`ifdef SCANOUT_PIXEL_DOUBLE_EN
  logic [ADDR_W-1:0]      line_start_r;
`endif

  // Next raster position and what S0 will issue there; sync windows of the current position
  always_comb begin
    h_nxt_s = h_cnt_r + HW'(1);
    v_nxt_s = v_cnt_r;
    if (h_cnt_r == H_LAST) begin
      h_nxt_s = '0;
      if (v_cnt_r == V_LAST) begin
        v_nxt_s = '0;
      end else begin
        v_nxt_s = v_cnt_r + VW'(1);
      end
    end else begin
      h_nxt_s = h_cnt_r + HW'(1);
    end
    vis_nxt_s    = (h_nxt_s < H_VIS_C) && (v_nxt_s < V_VIS_C);
    origin_nxt_s = (h_nxt_s == '0) && (v_nxt_s == '0);
`ifdef SCANOUT_PIXEL_DOUBLE_EN
    issue_nxt_s  = vis_nxt_s && !h_nxt_s[0];
`else
    issue_nxt_s  = vis_nxt_s;
`endif
    hs_act_s  = (h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END);
    vs_act_s  = (v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END);
    swap_pt_s = (h_cnt_r == '0) && (v_cnt_r == V_VIS_C) && swap_req;
  end

  // S0: raster counters, read strobe and incrementing read pointer (address of the current fetch)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_r      <= '0;
      v_cnt_r      <= '0;
      vis_r        <= 1'b0;
      rd_en        <= 1'b0;
      frame_start  <= 1'b0;
      rd_addr      <= '0;
`ifdef SCANOUT_PIXEL_DOUBLE_EN
      line_start_r <= '0;
`endif
    end else begin
      h_cnt_r     <= h_nxt_s;
      v_cnt_r     <= v_nxt_s;
      vis_r       <= vis_nxt_s;
      rd_en       <= issue_nxt_s;
      frame_start <= origin_nxt_s;
      if (origin_nxt_s) begin
        rd_addr      <= '0;
`ifdef SCANOUT_PIXEL_DOUBLE_EN
        line_start_r <= '0;
`endif
      end else if (issue_nxt_s) begin
`ifdef SCANOUT_PIXEL_DOUBLE_EN
        // Odd lines replay the even line above them; even lines continue past it
        if ((h_nxt_s == '0) && v_nxt_s[0]) begin
          rd_addr <= line_start_r;
        end else if (rd_addr != LAST_ADDR) begin
          rd_addr <= rd_addr + ADDR_W'(1);
          if (h_nxt_s == '0) begin
            line_start_r <= rd_addr + ADDR_W'(1);
          end
        end
`else
        if (rd_addr != LAST_ADDR) begin
          rd_addr <= rd_addr + ADDR_W'(1);
        end
`endif
      end
    end
  end

  // Front/back selection: toggles only when a request is present at vblank start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_buf   <= 1'b0;
      swap_ack <= 1'b0;
    end else if (swap_pt_s) begin
      rd_buf   <= ~rd_buf;
      swap_ack <= 1'b1;
    end else begin
      swap_ack <= 1'b0;
    end
  end

  // S1/S2: delay sync and de to meet the memory data, then register the pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_de_r    <= 1'b0;
      s1_fetch_r <= 1'b0;
      s1_hs_r    <= 1'b1;
      s1_vs_r    <= 1'b1;
      de         <= 1'b0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      pix_r      <= '0;
    end else begin
      s1_de_r    <= vis_r;
      s1_fetch_r <= rd_en;
      s1_hs_r    <= ~hs_act_s;
      s1_vs_r    <= ~vs_act_s;
      de         <= s1_de_r;
      hsync      <= s1_hs_r;
      vsync      <= s1_vs_r;
      if (!s1_de_r) begin
        pix_r <= '0;
      end else if (s1_fetch_r) begin
        pix_r <= rd_data;
      end
    end
  end

  assign {r, g, b} = pix_r;

endmodule

// File: tb/tb_frame_scanout_reader.sv
// Directed bench for frame_scanout_reader on a reduced 24x18 raster (16x12 visible);
// honours SCANOUT_PIXEL_DOUBLE_EN when defined.
module tb_frame_scanout_reader;

  localparam int H_VIS = 16, H_FP = 2, H_SYNC = 4, H_BP = 2;
  localparam int V_VIS = 12, V_FP = 2, V_SYNC = 2, V_BP = 2;
  localparam int H_TOT = 24, V_TOT = 18, FRAME = 432;
  localparam int COLOR_W = 4, ADDR_W = 19;
`ifdef SCANOUT_PIXEL_DOUBLE_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              swap_req = 1'b0;
  logic              swap_ack, rd_buf, rd_en, frame_start, hsync, vsync, de;
  logic [ADDR_W-1:0] rd_addr;
  logic [11:0]       rd_data = 12'h000;
  logic [3:0]        r, g, b;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit armed = 1'b0;
  logic prev_buf = 1'b0;
  int ack_cnt = 0, last_fetch = 0;
  int win_de = 0, win_hs = 0, win_vs = 0, last_de = 0, last_hs = 0, last_vs = 0;
  int rd_en_bad = 0, addr_bad = 0, de_bad = 0, rgb_bad = 0, blank_bad = 0, fs_bad = 0, buf_bad = 0;

  frame_scanout_reader #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .COLOR_W(COLOR_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .swap_req(swap_req), .swap_ack(swap_ack), .rd_buf(rd_buf),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .de(de), .r(r), .g(g), .b(b)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Memory: returns the low 12 address bits one cycle after rd_en
  always @(posedge clk) begin
    if (rd_en) rd_data <= rd_addr[11:0];
  end

  function automatic bit vis_at(input int p);
    return ((p % H_TOT) < H_VIS) && ((p / H_TOT) < V_VIS);
  endfunction

  function automatic bit issue_at(input int p);
    return vis_at(p) && (!DBL || (((p % H_TOT) % 2) == 0));
  endfunction

  function automatic int addr_at(input int p);
    int h, v;
    h = p % H_TOT;
    v = p / H_TOT;
    if (DBL) return (v / 2) * (H_VIS / 2) + h / 2;
    return v * H_VIS + h;
  endfunction

  // Continuous observation against the position model once a full frame is under way
  always @(negedge clk) begin
    if (rst) begin
      armed    <= 1'b0;
      prev_buf <= 1'b0;
      win_de   <= 0;
      win_hs   <= 0;
      win_vs   <= 0;
    end else begin
      prev_buf <= rd_buf;
      if (swap_ack) ack_cnt <= ack_cnt + 1;
      if (rd_en) last_fetch <= int'(rd_addr);
      if ((rd_buf != prev_buf) && ((cyc % FRAME) != V_VIS * H_TOT + 1)) buf_bad <= buf_bad + 1;
      if (frame_start) begin
        armed <= 1'b1;
        if (armed) begin
          last_de <= win_de;
          last_hs <= win_hs;
          last_vs <= win_vs;
        end
        win_de <= int'(de);
        win_hs <= int'(!hsync);
        win_vs <= int'(!vsync);
      end else begin
        win_de <= win_de + int'(de);
        win_hs <= win_hs + int'(!hsync);
        win_vs <= win_vs + int'(!vsync);
      end
      if (armed || frame_start) begin
        if (rd_en != issue_at(cyc % FRAME)) rd_en_bad <= rd_en_bad + 1;
        if (rd_en && (int'(rd_addr) != addr_at(cyc % FRAME))) addr_bad <= addr_bad + 1;
        if (de != vis_at((cyc + FRAME - 2) % FRAME)) de_bad <= de_bad + 1;
        if (de && ({r, g, b} != 12'(addr_at((cyc + FRAME - 2) % FRAME)))) rgb_bad <= rgb_bad + 1;
        if (!de && ({r, g, b} != 12'h000)) blank_bad <= blank_bad + 1;
        if (frame_start != ((cyc % FRAME) == 0)) fs_bad <= fs_bad + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_rst_outputs(input string tag);
    check({tag, "_ctl"}, 32'({hsync, vsync, de, rd_en, swap_ack, frame_start, rd_buf}), 32'(7'b1100000));
    check({tag, "_rgb"}, 32'({r, g, b}), 32'h0);
    check({tag, "_addr"}, 32'(rd_addr), 32'h0);
  endtask

  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    while (((cyc % FRAME) != v * H_TOT + h) && (n < 2 * FRAME)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2 * FRAME) check("goto_timeout", 32'(n), 32'h0);
  endtask

  task automatic pin_at(input int h, input int v);
    goto(h, v);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_fs(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && (n < 2 * FRAME));
    check(tag, 32'(cyc), 32'(exp));
  endtask

  initial begin
    int a0;
    #1 rst = 1'b1;
    #2 check_rst_outputs("rst_async");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    wait_fs("fs_first", FRAME);
    goto(0, 1);
    check("addr_line1", 32'(rd_addr), DBL ? 32'd0 : 32'd16);
    goto(0, 2);
    check("addr_line2", 32'(rd_addr), DBL ? 32'd8 : 32'd32);
    goto(5, 2);
    check("rd_en_5_2", 32'(rd_en), DBL ? 32'd0 : 32'd1);
    check("addr_5_2", 32'(rd_addr), DBL ? 32'd10 : 32'd37);
    repeat (2) @(negedge clk);
    check("de_5_2", 32'(de), 32'd1);
    check("rgb_5_2", 32'({r, g, b}), DBL ? 32'd10 : 32'd37);
    pin_at(17, 3);  check("hs_17", 32'(hsync), 32'd1);
    pin_at(18, 4);  check("hs_18", 32'(hsync), 32'd0);
    pin_at(21, 5);  check("hs_21", 32'(hsync), 32'd0);
    pin_at(22, 6);  check("hs_22", 32'(hsync), 32'd1);
    goto(0, 12);
    check("last_fetch", 32'(last_fetch), DBL ? 32'd47 : 32'd191);
    pin_at(20, 13); check("vs_13", 32'(vsync), 32'd1);
    pin_at(0, 14);  check("vs_14", 32'(vsync), 32'd0);
    pin_at(20, 15); check("vs_15", 32'(vsync), 32'd0);
    pin_at(0, 16);  check("vs_16", 32'(vsync), 32'd1);
    wait_fs("fs_second", 2 * FRAME);
    @(negedge clk);
    check("de_per_frame", 32'(last_de), 32'd192);
    check("hs_low_per_frame", 32'(last_hs), 32'd72);
    check("vs_low_per_frame", 32'(last_vs), 32'd48);

    // Request raised mid-frame, dropped right after the ack
    goto(0, 5);
    swap_req = 1'b1;
    goto(0, 12);
    check("buf_before_swap", 32'(rd_buf), 32'd0);
    @(negedge clk);
    check("buf_after_swap", 32'(rd_buf), 32'd1);
    check("ack_pulse", 32'(swap_ack), 32'd1);
    swap_req = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", 32'(swap_ack), 32'd0);
    a0 = ack_cnt;
    repeat (FRAME) @(negedge clk);
    check("no_second_ack", 32'(ack_cnt - a0), 32'd0);

    // Request first raised in the swap-point cycle itself
    goto(0, 12);
    check("buf_before_late", 32'(rd_buf), 32'd1);
    swap_req = 1'b1;
    @(negedge clk);
    check("buf_after_late", 32'(rd_buf), 32'd0);
    check("ack_late", 32'(swap_ack), 32'd1);
    swap_req = 1'b0;

    // Request held for three frames
    goto(0, 5);
    a0 = ack_cnt;
    swap_req = 1'b1;
    repeat (3 * FRAME) @(negedge clk);
    swap_req = 1'b0;
    @(negedge clk);
    check("held_acks", 32'(ack_cnt - a0), 32'd3);
    check("held_buf", 32'(rd_buf), 32'd1);

    // Request withdrawn before vblank
    goto(0, 8);
    a0 = ack_cnt;
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    repeat (FRAME) @(negedge clk);
    check("cancel_acks", 32'(ack_cnt - a0), 32'd0);
    check("cancel_buf", 32'(rd_buf), 32'd1);

    // Asynchronous reset mid-frame with buffer B in front and a request pending
    goto(10, 7);
    check("buf_pre_rst", 32'(rd_buf), 32'd1);
    swap_req = 1'b1;
    #2 rst = 1'b1;
    #1 check_rst_outputs("rst_mid");
    swap_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_fs("fs_after_rst", FRAME);
    check("buf_after_rst", 32'(rd_buf), 32'd0);

    @(negedge clk);
    check("rd_en_pattern", 32'(rd_en_bad), 32'd0);
    check("addr_sequence", 32'(addr_bad), 32'd0);
    check("de_alignment", 32'(de_bad), 32'd0);
    check("rgb_data", 32'(rgb_bad), 32'd0);
    check("rgb_blanking", 32'(blank_bad), 32'd0);
    check("frame_start_timing", 32'(fs_bad), 32'd0);
    check("buf_change_point", 32'(buf_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
